// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer for the equal-precision frequency meter: gate window, count
// capture, and freq = cnt_test * CLK_STAND_FREQ / cnt_stand through a 64-step divider.
module freq_meas_ctrl #(
    parameter int unsigned CNT_PRE        = 25_000_000,
    parameter int unsigned CNT_GATE       = 100_000_000,
    parameter int unsigned CNT_POST       = 25_000_000,
    parameter int unsigned CLK_STAND_FREQ = 100_000_000,
    parameter int unsigned TIMEOUT        = 50_000_000
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_start,
    input  logic        i_cont_mode,
    input  logic        i_abort,
    input  logic        i_cnt_valid,
    input  logic [31:0] i_cnt_test,
    input  logic [31:0] i_cnt_stand,
    output logic        o_gate_s,
    output logic        o_busy,
    output logic [31:0] o_freq,
    output logic        o_freq_valid,
    output logic        o_err_zero,
    output logic        o_err_timeout
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_GATE, S_POST, S_WAIT, S_MUL, S_DIV, S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt, r_test, r_stand, r_rem, r_freq;
    logic [63:0] r_quo;
    logic        r_have, r_gate, r_busy, r_fv, r_ez, r_et;

    logic [63:0] w_prod;
    logic [32:0] w_rem_sh;
    logic        w_fits;
    logic [31:0] w_rem_nx;
    logic [63:0] w_quo_nx;
    logic        w_capture;

    assign w_prod    = 64'(r_test) * 64'(CLK_STAND_FREQ);
    // Restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    // The remainder stays below the 32-bit divisor, so the low 32 bits hold it exactly.
    assign w_rem_sh  = {r_rem, r_quo[63]};
    assign w_fits    = (w_rem_sh >= {1'b0, r_stand});
    assign w_rem_nx  = w_fits ? (w_rem_sh[31:0] - r_stand) : w_rem_sh[31:0];
    assign w_quo_nx  = {r_quo[62:0], w_fits};
    assign w_capture = i_cnt_valid &&
                       (r_state == S_GATE || r_state == S_POST || r_state == S_WAIT);

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_test  <= '0;
            r_stand <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_freq  <= '0;
            r_have  <= 1'b0;
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
            r_fv    <= 1'b0;
            r_ez    <= 1'b0;
            r_et    <= 1'b0;
        end else begin
            r_fv <= 1'b0;
            r_ez <= 1'b0;
            r_et <= 1'b0;
            if (w_capture) begin
                r_test  <= i_cnt_test;
                r_stand <= i_cnt_stand;
                r_have  <= 1'b1;
            end
            if (i_abort && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_gate  <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if ((i_start || i_cont_mode) && !i_abort) begin
                        r_state <= S_PRE;
                        r_cnt   <= '0;
                        r_have  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                    S_PRE: if (r_cnt == CNT_PRE - 1) begin
                        r_state <= S_GATE;
                        r_cnt   <= '0;
                        r_gate  <= 1'b1;
                    end else r_cnt <= r_cnt + 32'd1;
                    S_GATE: if (r_cnt == CNT_GATE - 1) begin
                        r_state <= S_POST;
                        r_cnt   <= '0;
                        r_gate  <= 1'b0;
                    end else r_cnt <= r_cnt + 32'd1;
                    S_POST: if (r_cnt == CNT_POST - 1) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end else r_cnt <= r_cnt + 32'd1;
                    // A strobe on the expiry cycle still wins over the timeout.
                    S_WAIT: if (r_have || i_cnt_valid) begin
                        r_state <= S_MUL;
                    end else if (r_cnt == TIMEOUT - 1) begin
                        r_et    <= 1'b1;
                        r_state <= i_cont_mode ? S_PRE : S_IDLE;
                        r_busy  <= i_cont_mode;
                        r_cnt   <= '0;
                        r_have  <= 1'b0;
                    end else r_cnt <= r_cnt + 32'd1;
                    S_MUL: if (r_stand == '0) begin
                        r_ez    <= 1'b1;
                        r_state <= i_cont_mode ? S_PRE : S_IDLE;
                        r_busy  <= i_cont_mode;
                        r_cnt   <= '0;
                        r_have  <= 1'b0;
                    end else begin
                        r_quo   <= w_prod;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_DIV;
                    end
                    S_DIV: begin
                        r_quo <= w_quo_nx;
                        r_rem <= w_rem_nx;
                        if (r_cnt == 32'd63) begin
                            r_freq  <= (w_quo_nx[63:32] != '0) ? 32'hFFFF_FFFF : w_quo_nx[31:0];
                            r_fv    <= 1'b1;
                            r_state <= S_DONE;
                        end else r_cnt <= r_cnt + 32'd1;
                    end
                    S_DONE: begin
                        r_state <= i_cont_mode ? S_PRE : S_IDLE;
                        r_busy  <= i_cont_mode;
                        r_cnt   <= '0;
                        r_have  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_gate_s      = r_gate;
    assign o_busy        = r_busy;
    assign o_freq        = r_freq;
    assign o_freq_valid  = r_fv;
    assign o_err_zero    = r_ez;
    assign o_err_timeout = r_et;
endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl with shrunk timing parameters.
module tb_freq_meas_ctrl;
    localparam int BOUND = 300;

    logic        clk = 1'b0;
    logic        rst, start, cont, abrt, cnt_valid;
    logic [31:0] cnt_test, cnt_stand;
    logic        gate_s, busy, freq_valid, err_zero, err_timeout;
    logic [31:0] freq;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_freq = '0;

    freq_meas_ctrl #(
        .CNT_PRE(4), .CNT_GATE(16), .CNT_POST(4),
        .CLK_STAND_FREQ(100_000_000), .TIMEOUT(32)
    ) dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_start(start), .i_cont_mode(cont),
        .i_abort(abrt), .i_cnt_valid(cnt_valid), .i_cnt_test(cnt_test),
        .i_cnt_stand(cnt_stand), .o_gate_s(gate_s), .o_busy(busy), .o_freq(freq),
        .o_freq_valid(freq_valid), .o_err_zero(err_zero), .o_err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // kind: 0 = freq_valid, 1 = err_zero, 2 = err_timeout. exp_cyc < 0 skips the timing check.
    task automatic meas(input logic [31:0] t1, input logic [31:0] s1, input int c1,
                        input logic [31:0] t2, input logic [31:0] s2, input int c2,
                        input int start_at, input int exp_kind, input int exp_cyc,
                        input logic [31:0] exp_freq, input string tag);
        int p = -1, kind = -1, npulse = 0, gate_bad = 0, busy_bad = 0;
        logic [31:0] f_at = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= BOUND; c++) begin
            if (freq_valid || err_zero || err_timeout) begin
                p      = c;
                kind   = freq_valid ? 0 : (err_zero ? 1 : 2);
                npulse = int'(freq_valid) + int'(err_zero) + int'(err_timeout);
                f_at   = freq;
                break;
            end
            if (gate_s !== ((c >= 5) && (c <= 20))) gate_bad++;
            if (busy !== 1'b1) busy_bad++;
            cnt_valid = (c == c1) || (c == c2);
            cnt_test  = (c == c1) ? t1 : t2;
            cnt_stand = (c == c1) ? s1 : s2;
            start     = (c == start_at);
            tick();
        end
        cnt_valid = 1'b0;
        start     = 1'b0;
        if (p < 0) begin
            chk({tag, "_no_result_within_bound"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_gate"}, 64'(gate_bad), 64'd0);
            chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
            chk({tag, "_kind"}, 64'(kind), 64'(exp_kind));
            chk({tag, "_npulse"}, 64'(npulse), 64'd1);
            if (exp_cyc >= 0) chk({tag, "_cycle"}, 64'(p), 64'(exp_cyc));
            chk({tag, "_freq"}, 64'(f_at), 64'(exp_freq));
            tick();
            chk({tag, "_idle_after"}, {62'd0, busy, freq_valid}, 64'd0);
        end
        if (exp_kind == 0) model_freq = exp_freq;
    endtask

    // Reference: first strobe from GATE onward decides when WAIT ends; the last
    // strobe seen up to that point supplies the counts.
    task automatic model(input logic [31:0] t1, input logic [31:0] s1, input int c1,
                         input logic [31:0] t2, input logic [31:0] s2, input int c2,
                         output int kind, output int cyc, output logic [31:0] f);
        int first = 1000, w, best = -1;
        logic [31:0] t = '0, s = '0;
        logic [63:0] q;
        if (c1 >= 5 && c1 <= 56) first = c1;
        if (c2 >= 5 && c2 <= 56 && c2 < first) first = c2;
        if (first == 1000) begin
            kind = 2; cyc = 57; f = model_freq;
        end else begin
            w = (first < 25) ? 25 : first;
            if (c1 >= 5 && c1 <= w) begin best = c1; t = t1; s = s1; end
            if (c2 >= 5 && c2 <= w && c2 > best) begin t = t2; s = s2; end
            if (s == '0) begin
                kind = 1; cyc = -1; f = model_freq;
            end else begin
                q    = (64'(t) * 64'd100_000_000) / 64'(s);
                f    = (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
                kind = 0; cyc = w + 66;
            end
        end
    endtask

    typedef struct {
        logic [31:0] t1, s1; int c1;
        logic [31:0] t2, s2; int c2;
        int kind; int cyc; logic [31:0] freq;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int k_kind, k_cyc, c, cnt;
        logic [31:0] k_f, rt1, rs1, rt2, rs2;
        int rc1, rc2, sel;

        vecs[0] = '{32'd1000, 32'd100_000_000, 22, 32'd0, 32'd0, -1, 0, 91, 32'd1000};
        vecs[1] = '{32'd3, 32'd7, 25, 32'd0, 32'd0, -1, 0, 91, 32'd42_857_142};
        vecs[2] = '{32'hFFFF_FFFF, 32'd1, 30, 32'd0, 32'd0, -1, 0, 96, 32'hFFFF_FFFF};
        vecs[3] = '{32'd5, 32'd0, 10, 32'd0, 32'd0, -1, 1, -1, 32'hFFFF_FFFF};
        vecs[4] = '{32'd12345, 32'd50_000_000, 56, 32'd0, 32'd0, -1, 0, 122, 32'd24690};
        vecs[5] = '{32'd5, 32'd3, 3, 32'd0, 32'd0, -1, 2, 57, 32'd24690};
        vecs[6] = '{32'd5, 32'd3, 5, 32'd0, 32'd0, -1, 0, 91, 32'd166_666_666};
        vecs[7] = '{32'd1, 32'd1, 8, 32'd200, 32'd100_000_000, 24, 0, 91, 32'd200};

        rst = 1'b1; start = 1'b0; cont = 1'b0; abrt = 1'b0;
        cnt_valid = 1'b0; cnt_test = '0; cnt_stand = '0;
        repeat (3) tick();
        chk("reset_outputs", {busy, gate_s, freq_valid, err_zero, err_timeout, freq}, 64'd0);
        rst = 1'b0;
        cnt_valid = 1'b1; cnt_stand = 32'd1;
        repeat (4) tick();
        cnt_valid = 1'b0;
        chk("idle_ignores_cnt_valid", {busy, freq_valid, err_zero, err_timeout}, 64'd0);

        for (int i = 0; i < 8; i++)
            meas(vecs[i].t1, vecs[i].s1, vecs[i].c1, vecs[i].t2, vecs[i].s2, vecs[i].c2,
                 -1, vecs[i].kind, vecs[i].cyc, vecs[i].freq, $sformatf("vec%0d", i));

        // start pulsed mid-divide must be neither honoured nor queued
        meas(32'd9, 32'd3, 10, 32'd0, 32'd0, -1, 40, 0, 91, 32'd300_000_000, "start_in_div");

        // reset in the middle of the divide
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i < 50; i++) begin
            cnt_valid = (i == 10); cnt_test = 32'd7; cnt_stand = 32'd1;
            tick();
        end
        cnt_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_div_outputs", {busy, gate_s, freq_valid, err_zero, err_timeout, freq}, 64'd0);
        cnt = 0;
        repeat (100) begin tick(); if (freq_valid) cnt++; end
        chk("rst_div_no_result", {31'd0, busy, 32'(cnt)}, 64'd0);
        model_freq = '0;

        // continuous mode: timeout, automatic restart, then abort inside GATE
        cont = 1'b1; tick();
        c = 1; cnt = 0;
        while (c < BOUND && !err_timeout) begin
            if (freq_valid || err_zero) cnt++;
            tick(); c++;
        end
        chk("cont_timeout_cycle", 64'(c), 64'd57);
        chk("cont_timeout_state", {31'd0, busy, freq, 32'(cnt)}, {31'd0, 1'b1, 32'd0, 32'd0});
        repeat (3) tick();
        chk("cont_pre_gate_low", {63'd0, gate_s}, 64'd0);
        tick();
        chk("cont_gate_rises", {63'd0, gate_s}, 64'd1);
        repeat (3) tick();
        abrt = 1'b1; tick(); abrt = 1'b0; cont = 1'b0;
        chk("abort_gate_busy", {62'd0, gate_s, busy}, 64'd0);
        cnt = 0;
        repeat (20) begin tick(); if (freq_valid || err_zero || err_timeout) cnt++; end
        chk("abort_quiet", {31'd0, busy, 32'(cnt)}, 64'd0);

        for (int k = 0; k < 10; k++) begin
            rt1 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 5000));
            rt2 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 5000));
            sel = $urandom_range(0, 3);
            rs1 = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 16)) : $urandom;
            sel = $urandom_range(0, 3);
            rs2 = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 16)) : $urandom;
            rc1 = $urandom_range(1, 60);
            rc2 = $urandom_range(0, 1) ? -1 : int'($urandom_range(1, 60));
            if (rc2 == rc1) rc2 = -1;
            model(rt1, rs1, rc1, rt2, rs2, rc2, k_kind, k_cyc, k_f);
            meas(rt1, rs1, rc1, rt2, rs2, rc2, -1, k_kind, k_cyc, k_f, $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
Measurement sequencer for the equal-precision frequency meter.
- Generates the software gate window (pre-guard, gate, post-guard).
- Waits for the counting datapath to return latched test-clock and standard-clock counts.
- Computes freq = cnt_test * CLK_STAND_FREQ / cnt_stand with a 64-cycle sequential divider, replacing the single-cycle combinational divide.
- Sits between the top-level control (start / continuous mode) and the gated counter datapath. Runs entirely in the sys_clk domain.

Parameters:
- CNT_PRE, 25_000_000, sys_clk cycles of guard time before the gate opens (0.25 s at 100 MHz).
- CNT_GATE, 100_000_000, sys_clk cycles gate_s is held high (1 s).
- CNT_POST, 25_000_000, sys_clk cycles of guard time after the gate closes.
- CLK_STAND_FREQ, 100_000_000, standard reference clock frequency in Hz.
- TIMEOUT, 50_000_000, maximum sys_clk cycles to wait in WAIT for cnt_valid.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to run a single measurement.
- cont_mode  in  1  level; when 1, a new measurement restarts automatically after each one completes.
- abort  in  1  synchronous abort of the measurement in progress.
- cnt_valid  in  1  one-cycle strobe from the datapath; cnt_test and cnt_stand are valid on that cycle.
- cnt_test  in  32  test-clock edges counted during the actual gate.
- cnt_stand  in  32  standard-clock edges counted during the actual gate.
- gate_s  out  1  software gate, registered.
- busy  out  1  high in every state except IDLE.
- freq  out  32  last good result in Hz; holds its value between results.
- freq_valid  out  1  one-cycle pulse on the cycle freq updates.
- err_zero  out  1  one-cycle pulse when the divisor is zero.
- err_timeout  out  1  one-cycle pulse when the WAIT timeout expires.

Behaviour:
- Sampling: all logic samples on the rising edge of sys_clk.
- Reset (sys_rst=1): state=IDLE; gate_s, busy, freq_valid, err_zero, err_timeout = 0; freq = 0; phase counter and latched counts cleared. Reset has priority over every other input and takes effect from any state.
- States: IDLE, PRE, GATE, POST, WAIT, MUL, DIV, DONE.
- IDLE:
  - start=1 or cont_mode=1 -> PRE on the next cycle.
  - cnt_valid is ignored.
- PRE: runs exactly CNT_PRE cycles, then -> GATE. gate_s=0.
- GATE: gate_s=1 for exactly CNT_GATE cycles, then -> POST. gate_s rises CNT_PRE+1 cycles after the start sample.
- POST: runs CNT_POST cycles with gate_s=0, then -> WAIT.
- Count capture:
  - A cnt_valid seen during GATE, POST or WAIT latches cnt_test and cnt_stand and sets a sticky "have" flag.
  - A later cnt_valid overwrites the latched values.
  - The flag clears on entry to PRE.
- WAIT:
  - If the have flag is set -> MUL.
  - Else, after TIMEOUT cycles in WAIT -> pulse err_timeout, freq unchanged, go to the exit target.
- MUL:
  - If cnt_stand==0 -> pulse err_zero, go to the exit target.
  - Else form a 64-bit product: cnt_test * CLK_STAND_FREQ, unsigned, which fits without overflow.
- DIV:
  - Restoring division, one quotient bit per cycle, exactly 64 cycles.
  - 64-bit quotient; the result is truncated, not rounded.
- DONE:
  - freq = quotient[31:0] if quotient < 2^32, else freq = 32'hFFFF_FFFF (saturate).
  - freq_valid=1 for this cycle only.
  - Then go to the exit target.
- Exit target: PRE if cont_mode=1, else IDLE.
- Latency: freq_valid asserts exactly 66 cycles after the last WAIT cycle (1 MUL + 64 DIV + DONE).
- busy=1 in every state except IDLE.
- start while busy is ignored; it is not queued.
- abort=1 in any non-IDLE state:
  - -> IDLE on the next cycle, with gate_s=0 on that same cycle.
  - No freq_valid or error pulse; freq is held.
  - abort in IDLE has no effect.
  - abort overrides start and cont_mode in the same cycle.
- Simultaneous events:
  - cnt_valid on the cycle TIMEOUT expires -> the count is accepted; no err_timeout.
  - Reset during DIV discards the partial quotient.
- Error pulses and freq_valid are mutually exclusive per measurement.

Test Plan (CNT_PRE=4, CNT_GATE=16, CNT_POST=4, TIMEOUT=32, CLK_STAND_FREQ=100_000_000):
- Reset, then start at cycle 0:
  - gate_s is high for cycles 5..20 exactly; busy=1 from cycle 1.
  - Then cnt_valid with cnt_test=1000, cnt_stand=100_000_000 -> freq=1000, freq_valid 66 cycles after leaving WAIT, busy=0 afterwards.
- Truncation: cnt_test=3, cnt_stand=7 -> freq=42_857_142.
- Saturation:
  - cnt_test=32'hFFFF_FFFF, cnt_stand=1 -> freq=32'hFFFF_FFFF with freq_valid.
  - cnt_stand=0 -> err_zero pulse, no freq_valid, freq keeps its previous value.
- No cnt_valid after POST:
  - err_timeout pulses exactly 32 cycles after WAIT entry.
  - With cont_mode=1, PRE restarts on the next cycle and gate_s rises again.
- Mid-operation interruptions:
  - abort during GATE -> gate_s=0 and state IDLE on the next cycle, no result pulse.
  - start during DIV is ignored.
  - sys_rst during DIV -> all outputs return to reset values, including freq=0.
